// File: rtl/lfsr_source.sv
// Fibonacci LFSR bit source with seed-load handshake, loop/period tracking
// and all-zero lock-up detection.
module lfsr_source #(
  parameter int               WIDTH        = 8,
  parameter logic [WIDTH-1:0] TAPS         = 8'hB8,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = 8'h01
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             seed_valid,
  input  logic [WIDTH-1:0] seed_data,
  output logic             seed_ready,
  output logic             val,
  output logic             val_valid,
  output logic             loop,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] state,
  output logic             lockup
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    LOCKED = 2'd2
  } fsm_t;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  fsm_t             fsm_reg,       fsm_next;
  logic [WIDTH-1:0] lfsr_reg,      lfsr_next;
  logic [WIDTH-1:0] seed_reg,      seed_next;
  logic [WIDTH-1:0] step_reg,      step_next;
  logic [WIDTH-1:0] period_reg,    period_next;
  logic             val_reg,       val_next;
  logic             val_valid_reg, val_valid_next;
  logic             loop_reg,      loop_next;
  logic             lockup_reg,    lockup_next;

  logic             fb;
  logic [WIDTH-1:0] lfsr_step;
  logic             seed_take;

  assign fb        = ^(lfsr_reg & TAPS);
  assign lfsr_step = {lfsr_reg[WIDTH-2:0], fb};
  assign seed_take = seed_valid && seed_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_reg       <= IDLE;
      lfsr_reg      <= DEFAULT_SEED;
      seed_reg      <= DEFAULT_SEED;
      step_reg      <= '0;
      period_reg    <= '0;
      val_reg       <= 1'b0;
      val_valid_reg <= 1'b0;
      loop_reg      <= 1'b0;
      lockup_reg    <= 1'b0;
    end else begin
      fsm_reg       <= fsm_next;
      lfsr_reg      <= lfsr_next;
      seed_reg      <= seed_next;
      step_reg      <= step_next;
      period_reg    <= period_next;
      val_reg       <= val_next;
      val_valid_reg <= val_valid_next;
      loop_reg      <= loop_next;
      lockup_reg    <= lockup_next;
    end
  end

  always_comb begin
    fsm_next       = fsm_reg;
    lfsr_next      = lfsr_reg;
    seed_next      = seed_reg;
    step_next      = step_reg;
    period_next    = period_reg;
    val_next       = val_reg;
    val_valid_next = 1'b0;
    loop_next      = 1'b0;
    seed_ready     = (fsm_reg != RUN);

    unique case (fsm_reg)
      IDLE: begin
        if (seed_take) begin
          lfsr_next   = seed_data;
          seed_next   = seed_data;
          step_next   = '0;
          period_next = '0;
          if (seed_data == '0) begin
            fsm_next = LOCKED;
          end
        end else if (en) begin
          fsm_next = RUN;
        end
      end

      RUN: begin
        if (en) begin
          lfsr_next      = lfsr_step;
          val_next       = lfsr_reg[WIDTH-1];
          val_valid_next = 1'b1;
          // Loop is detected on the step that lands back on the seed, so
          // the pulse coincides with that step's val_valid.
          if (lfsr_step == seed_reg) begin
            loop_next   = 1'b1;
            period_next = step_reg + ONE;
            step_next   = '0;
          end else begin
            step_next   = step_reg + ONE;
          end
        end else begin
          fsm_next = IDLE;
        end
      end

      LOCKED: begin
        if (seed_take) begin
          lfsr_next   = seed_data;
          seed_next   = seed_data;
          step_next   = '0;
          period_next = '0;
          if (seed_data != '0) begin
            fsm_next = IDLE;
          end
        end
      end

      default: begin
        fsm_next = IDLE;
      end
    endcase

    // Zero is a fixed point of the shift, so flag it whatever got us there.
    lockup_next = (lfsr_next == '0);
  end

  assign val       = val_reg;
  assign val_valid = val_valid_reg;
  assign loop      = loop_reg;
  assign period    = period_reg;
  assign state     = lfsr_reg;
  assign lockup    = lockup_reg;

endmodule

// File: tb/tb_lfsr_source.sv
// Directed bench for lfsr_source: default 8-bit instance plus a 4-bit
// non-maximal instance.
module tb_lfsr_source;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       seed_valid;
  logic [7:0] seed_data;
  logic       seed_ready;
  logic       val;
  logic       val_valid;
  logic       loop;
  logic [7:0] period;
  logic [7:0] state;
  logic       lockup;

  logic       en4;
  logic       seed_valid4;
  logic [3:0] seed_data4;
  logic       seed_ready4;
  logic       val4;
  logic       val_valid4;
  logic       loop4;
  logic [3:0] period4;
  logic [3:0] state4;
  logic       lockup4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lfsr_source u8 (
    .clk(clk), .reset(reset), .en(en),
    .seed_valid(seed_valid), .seed_data(seed_data), .seed_ready(seed_ready),
    .val(val), .val_valid(val_valid), .loop(loop),
    .period(period), .state(state), .lockup(lockup)
  );

  lfsr_source #(.WIDTH(4), .TAPS(4'hA), .DEFAULT_SEED(4'h1)) u4 (
    .clk(clk), .reset(reset), .en(en4),
    .seed_valid(seed_valid4), .seed_data(seed_data4), .seed_ready(seed_ready4),
    .val(val4), .val_valid(val_valid4), .loop(loop4),
    .period(period4), .state(state4), .lockup(lockup4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] m;
    logic       vexp;
    logic [3:0] exp4_state [6];
    logic       exp4_val   [6];

    reset = 1'b1; en = 1'b0; seed_valid = 1'b0; seed_data = 8'h00;
    en4 = 1'b0; seed_valid4 = 1'b0; seed_data4 = 4'h0;
    tick; tick;

    // Reset state
    chk("rst_state", state, 8'h01);
    chk("rst_val", val, 0);
    chk("rst_vvalid", val_valid, 0);
    chk("rst_loop", loop, 0);
    chk("rst_period", period, 0);
    chk("rst_lockup", lockup, 0);
    chk("rst_ready", seed_ready, 1);
    #2 reset = 1'b0;

    // Test 1: IDLE->RUN edge does not step; then 02,04,08,11
    en = 1'b1;
    tick;
    chk("t1_run_state", state, 8'h01);
    chk("t1_run_vvalid", val_valid, 0);
    chk("t1_run_ready", seed_ready, 0);
    tick; chk("t1_s1", state, 8'h02); chk("t1_v1", val, 0); chk("t1_vv1", val_valid, 1);
    tick; chk("t1_s2", state, 8'h04); chk("t1_v2", val, 0); chk("t1_vv2", val_valid, 1);
    tick; chk("t1_s3", state, 8'h08); chk("t1_v3", val, 0); chk("t1_vv3", val_valid, 1);
    tick; chk("t1_s4", state, 8'h11); chk("t1_v4", val, 0); chk("t1_vv4", val_valid, 1);

    // Test 2: steps 5..510 against a reference shift; loop at 255 and 510
    m = 8'h11;
    for (int k = 5; k <= 510; k++) begin
      vexp = m[7];
      m = {m[6:0], ^(m & 8'hB8)};
      tick;
      chk("t2_state", state, m);
      chk("t2_val", val, vexp);
      chk("t2_vvalid", val_valid, 1);
      chk("t2_loop", loop, (k == 255 || k == 510));
      if (k == 254) chk("t2_period_pre", period, 0);
      if (k == 255) begin
        chk("t2_state255", state, 8'h01);
        chk("t2_period255", period, 255);
      end
      if (k == 256) chk("t2_loop_off", loop, 0);
      if (k == 510) chk("t2_period510", period, 255);
    end

    // Test 5: seed offered in RUN is ignored
    seed_valid = 1'b1; seed_data = 8'h55;
    tick; chk("t5_s1", state, 8'h02); chk("t5_ready_run", seed_ready, 0);
    tick; chk("t5_s2", state, 8'h04);
    tick; chk("t5_s3", state, 8'h08);
    en = 1'b0;
    tick;
    chk("t5_idle_state", state, 8'h08);
    chk("t5_idle_vvalid", val_valid, 0);
    chk("t5_idle_ready", seed_ready, 1);
    chk("t5_idle_period", period, 255);
    tick;
    chk("t5_load_state", state, 8'h55);
    chk("t5_load_period", period, 0);
    chk("t5_load_ready", seed_ready, 1);
    chk("t5_load_lockup", lockup, 0);

    // Test 4: zero seed -> LOCKED; en ignored; non-zero seed recovers
    seed_data = 8'h00;
    tick;
    seed_valid = 1'b0;
    chk("t4_lock", lockup, 1);
    chk("t4_lock_ready", seed_ready, 1);
    chk("t4_lock_state", state, 8'h00);
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("t4_lock_vvalid", val_valid, 0);
      chk("t4_lock_hold", lockup, 1);
    end
    seed_valid = 1'b1; seed_data = 8'h3C;
    tick;
    seed_valid = 1'b0;
    chk("t4_unlock", lockup, 0);
    chk("t4_unlock_state", state, 8'h3C);
    chk("t4_unlock_ready", seed_ready, 1);
    tick;
    chk("t4_prio_run_state", state, 8'h3C);
    chk("t4_prio_ready", seed_ready, 0);
    chk("t4_prio_vvalid", val_valid, 0);
    tick; chk("t4_s1", state, 8'h79); chk("t4_v1", val, 0); chk("t4_vv1", val_valid, 1);
    tick; chk("t4_s2", state, 8'hF3); chk("t4_v2", val, 0);
    tick; chk("t4_s3", state, 8'hE7); chk("t4_v3", val, 1);

    // Test 6: asynchronous reset mid-cycle at state 11
    en = 1'b0;
    tick;
    seed_valid = 1'b1; seed_data = 8'h01;
    tick;
    seed_valid = 1'b0; en = 1'b1;
    tick;
    for (int i = 0; i < 4; i++) tick;
    chk("t6_pre_state", state, 8'h11);
    chk("t6_pre_vvalid", val_valid, 1);
    #3 reset = 1'b1;
    #1;
    chk("t6_state", state, 8'h01);
    chk("t6_vvalid", val_valid, 0);
    chk("t6_loop", loop, 0);
    chk("t6_ready", seed_ready, 1);
    chk("t6_period", period, 0);
    en = 1'b0;
    tick;
    reset = 1'b0;

    // Test 3: 4-bit, taps A, seed 1 -> 2,5,A,4,8,1, loop at step 6
    exp4_state = '{4'h2, 4'h5, 4'hA, 4'h4, 4'h8, 4'h1};
    exp4_val   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    en4 = 1'b1;
    tick;
    chk("t3_run_state", state4, 4'h1);
    for (int k = 0; k < 6; k++) begin
      tick;
      chk("t3_state", state4, exp4_state[k]);
      chk("t3_val", val4, exp4_val[k]);
      chk("t3_vvalid", val_valid4, 1);
      chk("t3_loop", loop4, (k == 5));
      chk("t3_period", period4, (k == 5) ? 6 : 0);
    end
    tick;
    chk("t3_s7", state4, 4'h2);
    chk("t3_loop_off", loop4, 0);
    chk("t3_period_keep", period4, 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
